// File: rtl/dcm_phase_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : dcm_phase_ctl_if
// Brief    : Command and DCM-pin bundle for the dcm333 fine-phase sequencer.
//            The master side drives the commands and reflects the DCM status
//            pins. The slave side is the sequencer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface dcm_phase_ctl_if #(
   parameter int PHASE_W = 9
);
   // DCM status (locked is asynchronous to dcm_clk)
   logic                      locked;
   logic                      dcm_done;
   // Phase requests
   logic                      cmd_set;
   logic                      cmd_inc;
   logic                      cmd_dec;
   logic signed [PHASE_W-1:0] target;
   // DCM phase-shift pins and status back to the requester
   logic                      dcm_en;
   logic                      dcm_incdec;
   logic signed [PHASE_W-1:0] cur_phase;
   logic                      busy;
   logic                      err;

   modport master (
      output locked, dcm_done, cmd_set, cmd_inc, cmd_dec, target,
      input  dcm_en, dcm_incdec, cur_phase, busy, err
   );

   modport slave (
      input  locked, dcm_done, cmd_set, cmd_inc, cmd_dec, target,
      output dcm_en, dcm_incdec, cur_phase, busy, err
   );
endinterface
`default_nettype wire

// File: rtl/dcm_phase_ctl.sv
`default_nettype none
// ============================================================================
// Module   : dcm_phase_ctl
// Brief    : Fine-phase sequencer for the dcm333 SDRAM-clock DCM. Turns
//            absolute-target and single-step requests into one-cycle
//            PSEN/PSINCDEC pulses. After each pulse it waits for the DCM
//            done handshake and tracks the resulting signed phase.
// Revision : 1.0 - initial release
// ============================================================================
module dcm_phase_ctl #(
   parameter int PHASE_W  = 9,
   parameter int PH_LIMIT = 255,
   parameter int TMO_W    = 6
) (
   input  wire logic      dcm_clk,
   input  wire logic      dcm_rst,
   dcm_phase_ctl_if.slave io_ctl
);

   // Clamp arithmetic runs one bit wider so that +/-PH_LIMIT +/- 1 never wraps
   localparam int                        EXT_W     = PHASE_W + 1;
   localparam logic signed [EXT_W-1:0]   c_lim_pos = EXT_W'(PH_LIMIT);
   localparam logic signed [EXT_W-1:0]   c_lim_neg = -c_lim_pos;
   localparam logic signed [EXT_W-1:0]   c_one_ext = EXT_W'(1);
   localparam logic signed [PHASE_W-1:0] c_one     = PHASE_W'(1);
   localparam logic [TMO_W-1:0]          c_tmo_max = {TMO_W{1'b1}};

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_IDLE      = 2'd1,
      S_STEP      = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t                    r_state, w_state_nx;
   logic                      r_lock_s1, r_lock_s2;
   logic signed [PHASE_W-1:0] r_tgt, w_tgt_nx;
   logic signed [PHASE_W-1:0] r_cur, w_cur_nx, w_cur_step;
   logic                      r_dir, w_dir_nx;
   logic [TMO_W-1:0]          r_tmo, w_tmo_nx;
   logic                      r_err, w_err_nx;

   logic signed [EXT_W-1:0]   w_cur_ext, w_target_ext;
   logic signed [EXT_W-1:0]   w_set_ext, w_inc_ext, w_dec_ext;
   logic                      w_active, w_acc_set, w_acc_step, w_up;

   // Bring the asynchronous DCM lock flag into the dcm_clk domain
   always_ff @(posedge dcm_clk or posedge dcm_rst) begin
      if (dcm_rst) begin
         r_lock_s1 <= 1'b0;
         r_lock_s2 <= 1'b0;
      end else begin
         r_lock_s1 <= io_ctl.locked;
         r_lock_s2 <= r_lock_s1;
      end
   end

   // Candidate targets for each command, clamped to +/-PH_LIMIT
   always_comb begin
      w_cur_ext    = EXT_W'(r_cur);
      w_target_ext = EXT_W'(io_ctl.target);
      w_set_ext    = w_target_ext;
      if (w_target_ext > c_lim_pos) begin
         w_set_ext = c_lim_pos;
      end else if (w_target_ext < c_lim_neg) begin
         w_set_ext = c_lim_neg;
      end
      w_inc_ext = (w_cur_ext >= c_lim_pos) ? c_lim_pos : (w_cur_ext + c_one_ext);
      w_dec_ext = (w_cur_ext <= c_lim_neg) ? c_lim_neg : (w_cur_ext - c_one_ext);
   end

   // Command acceptance and the target the sequencer steers towards
   always_comb begin
      // Lock loss overrides any command arriving in the same cycle
      w_active   = (r_state != S_WAIT_LOCK) && r_lock_s2;
      // Absolute moves retarget at any time; steps only start from IDLE
      w_acc_set  = w_active && io_ctl.cmd_set;
      w_acc_step = w_active && (r_state == S_IDLE) && !io_ctl.cmd_set &&
                   (io_ctl.cmd_inc ^ io_ctl.cmd_dec);
      w_tgt_nx   = r_tgt;
      if (w_acc_set) begin
         w_tgt_nx = PHASE_W'(w_set_ext);
      end else if (w_acc_step) begin
         w_tgt_nx = io_ctl.cmd_inc ? PHASE_W'(w_inc_ext) : PHASE_W'(w_dec_ext);
      end
      w_up       = (r_tgt > r_cur);
      w_cur_step = r_dir ? (r_cur + c_one) : (r_cur - c_one);
   end

   // Next-state and datapath decisions for the step sequencer
   always_comb begin
      w_state_nx = r_state;
      w_cur_nx   = r_cur;
      w_dir_nx   = r_dir;
      w_tmo_nx   = r_tmo;
      w_err_nx   = r_err;
      if (w_acc_set || w_acc_step) begin
         w_err_nx = 1'b0;
      end
      case (r_state)
         S_WAIT_LOCK: begin
            if (r_lock_s2 && io_ctl.dcm_done) begin
               w_state_nx = S_IDLE;
            end
         end
         S_IDLE: begin
            if (!r_lock_s2) begin
               w_state_nx = S_WAIT_LOCK;
               w_err_nx   = 1'b1;
            end else if ((w_acc_set || w_acc_step) && (w_tgt_nx != r_cur)) begin
               w_state_nx = S_STEP;
            end
         end
         S_STEP: begin
            if (!r_lock_s2) begin
               w_state_nx = S_WAIT_LOCK;
               w_err_nx   = 1'b1;
            end else begin
               w_state_nx = S_WAIT_DONE;
               w_dir_nx   = w_up;
               w_tmo_nx   = '0;
            end
         end
         S_WAIT_DONE: begin
            if (!r_lock_s2) begin
               w_state_nx = S_WAIT_LOCK;
               w_err_nx   = 1'b1;
            end else if ((r_tmo != '0) && io_ctl.dcm_done) begin
               // The first cycle is blanked: done is still stale high then
               w_cur_nx   = w_cur_step;
               w_state_nx = (w_cur_step != w_tgt_nx) ? S_STEP : S_IDLE;
            end else if (r_tmo == c_tmo_max) begin
               w_state_nx = S_IDLE;
               w_err_nx   = 1'b1;
            end else begin
               w_tmo_nx = r_tmo + TMO_W'(1);
            end
         end
         default: begin
            w_state_nx = S_WAIT_LOCK;
         end
      endcase
   end

   // State and datapath registers; reset also zeroes the DCM phase itself
   always_ff @(posedge dcm_clk or posedge dcm_rst) begin
      if (dcm_rst) begin
         r_state <= S_WAIT_LOCK;
         r_tgt   <= '0;
         r_cur   <= '0;
         r_dir   <= 1'b0;
         r_tmo   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_tgt   <= w_tgt_nx;
         r_cur   <= w_cur_nx;
         r_dir   <= w_dir_nx;
         r_tmo   <= w_tmo_nx;
         r_err   <= w_err_nx;
      end
   end

   // PSEN is suppressed as soon as the synchronized lock drops
   assign io_ctl.dcm_en     = (r_state == S_STEP) && r_lock_s2;
   assign io_ctl.dcm_incdec = (r_state == S_STEP) && r_lock_s2 && w_up;
   assign io_ctl.cur_phase  = r_cur;
   assign io_ctl.busy       = (r_state != S_IDLE);
   assign io_ctl.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dcm_phase_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcm_phase_ctl
// Brief    : Self-checking bench for dcm_phase_ctl with a behavioural DCM
//            responder, a table of directed commands, randomized commands
//            and hand-written timeout, lock-loss and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcm_phase_ctl;

   localparam int PHASE_W  = 9;
   localparam int PH_LIMIT = 255;
   localparam int TMO_W    = 6;

   localparam int K_SET    = 0;
   localparam int K_INC    = 1;
   localparam int K_DEC    = 2;
   localparam int K_BOTH   = 3;
   localparam int K_SETINC = 4;

   typedef struct {
      int kind;
      int tgt;
      int exp_ph;
      int exp_up;
      int exp_dn;
   } vec_t;

   logic dcm_clk = 1'b0;
   logic dcm_rst;

   int checks   = 0;
   int failures = 0;
   int n_up     = 0;
   int n_dn     = 0;
   int dcm_ph   = 0;
   int m_cur    = 0;
   int lat      = 4;
   int age      = -1;
   bit hang     = 1'b0;
   bit prev_en  = 1'b0;

   vec_t tbl [12];

   dcm_phase_ctl_if #(.PHASE_W(PHASE_W)) u_if ();

   dcm_phase_ctl #(
      .PHASE_W  (PHASE_W),
      .PH_LIMIT (PH_LIMIT),
      .TMO_W    (TMO_W)
   ) u_dut (
      .dcm_clk (dcm_clk),
      .dcm_rst (dcm_rst),
      .io_ctl  (u_if)
   );

   always #5 dcm_clk = ~dcm_clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int clampi(input int v);
      if (v > PH_LIMIT)  return PH_LIMIT;
      if (v < -PH_LIMIT) return -PH_LIMIT;
      return v;
   endfunction

   // Where the phase should end up after one command, from the command rules
   function automatic int model_next(input int kind, input int tgt, input int cur);
      case (kind)
         K_SET, K_SETINC: return clampi(tgt);
         K_INC:           return clampi(cur + 1);
         K_DEC:           return clampi(cur - 1);
         default:         return cur;
      endcase
   endfunction

   // Behavioural DCM: done stays stale high one extra cycle after PSEN,
   // then drops and comes back lat cycles after the pulse (never if hung)
   initial begin
      u_if.dcm_done = 1'b1;
      forever begin
         @(negedge dcm_clk);
         if (dcm_rst) begin
            u_if.dcm_done = 1'b1;
            age     = -1;
            dcm_ph  = 0;
            prev_en = 1'b0;
         end else begin
            bit new_pulse;
            new_pulse = 1'b0;
            if (u_if.dcm_en) begin
               check("en_single_cycle", int'(prev_en), 0);
               check("en_when_ready", int'(u_if.dcm_done && (age < 0)), 1);
               if (u_if.dcm_incdec) begin
                  n_up++;
                  dcm_ph++;
               end else begin
                  n_dn++;
                  dcm_ph--;
               end
               new_pulse = 1'b1;
            end
            if (age >= 0) begin
               age++;
               if (age == 2) u_if.dcm_done = 1'b0;
               if (age >= lat && !hang) begin
                  u_if.dcm_done = 1'b1;
                  age = -1;
               end
            end
            if (new_pulse) age = 0;
            prev_en = u_if.dcm_en;
         end
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic strobe(input int kind, input int tgt);
      u_if.cmd_set = (kind == K_SET) || (kind == K_SETINC);
      u_if.cmd_inc = (kind == K_INC) || (kind == K_BOTH) || (kind == K_SETINC);
      u_if.cmd_dec = (kind == K_DEC) || (kind == K_BOTH);
      u_if.target  = PHASE_W'(tgt);
      @(negedge dcm_clk);
      u_if.cmd_set = 1'b0;
      u_if.cmd_inc = 1'b0;
      u_if.cmd_dec = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int limit);
      for (int i = 0; i < limit && u_if.busy; i++) @(negedge dcm_clk);
      check({nm, "_idle"}, int'(u_if.busy), 0);
   endtask

   task automatic wait_en(input string nm, input int limit);
      for (int i = 0; i < limit && !u_if.dcm_en; i++) @(negedge dcm_clk);
      check({nm, "_en_seen"}, int'(u_if.dcm_en), 1);
   endtask

   task automatic run_cmd(input int kind, input int tgt, input int exp_ph,
                          input int exp_up, input int exp_dn,
                          input string nm, input bit inject);
      int up0, dn0;
      up0 = n_up;
      dn0 = n_dn;
      strobe(kind, tgt);
      if (inject) begin
         // A step request while busy must be ignored
         u_if.cmd_inc = 1'b1;
         @(negedge dcm_clk);
         u_if.cmd_inc = 1'b0;
      end
      wait_idle(nm, 6000);
      check({nm, "_phase"}, int'(u_if.cur_phase), exp_ph);
      check({nm, "_up"}, n_up - up0, exp_up);
      check({nm, "_dn"}, n_dn - dn0, exp_dn);
      check({nm, "_err"}, int'(u_if.err), 0);
      check({nm, "_dcm_phase"}, dcm_ph, exp_ph);
      m_cur = exp_ph;
   endtask

   initial begin
      int cyc, up0, dn0, kind, tgt, exp;
      dcm_rst      = 1'b1;
      u_if.locked  = 1'b0;
      u_if.cmd_set = 1'b0;
      u_if.cmd_inc = 1'b0;
      u_if.cmd_dec = 1'b0;
      u_if.target  = '0;

      tbl[0]  = '{K_SET,     3,    3,   3,   0};
      tbl[1]  = '{K_INC,     0,    4,   1,   0};
      tbl[2]  = '{K_DEC,     0,    3,   0,   1};
      tbl[3]  = '{K_BOTH,    0,    3,   0,   0};
      tbl[4]  = '{K_SET,     3,    3,   0,   0};
      tbl[5]  = '{K_SET,  -256, -255,   0, 258};
      tbl[6]  = '{K_DEC,     0, -255,   0,   0};
      tbl[7]  = '{K_SET,   255,  255, 510,   0};
      tbl[8]  = '{K_INC,     0,  255,   0,   0};
      tbl[9]  = '{K_SETINC,  0,    0,   0, 255};
      tbl[10] = '{K_SET,    -1,   -1,   0,   1};
      tbl[11] = '{K_SET,     0,    0,   1,   0};

      // ---- reset state ----
      repeat (3) @(negedge dcm_clk);
      check("rst_en", int'(u_if.dcm_en), 0);
      check("rst_incdec", int'(u_if.dcm_incdec), 0);
      check("rst_phase", int'(u_if.cur_phase), 0);
      check("rst_busy", int'(u_if.busy), 1);
      check("rst_err", int'(u_if.err), 0);
      dcm_rst = 1'b0;

      // ---- lock acquisition ----
      repeat (5) @(negedge dcm_clk);
      check("unlocked_busy", int'(u_if.busy), 1);
      u_if.locked = 1'b1;
      cyc = 0;
      while (u_if.busy && cyc < 8) begin
         @(negedge dcm_clk);
         cyc++;
      end
      check("lock_idle", int'(u_if.busy), 0);
      check("lock_sync_min", int'(cyc >= 2), 1);
      check("lock_sync_max", int'(cyc <= 4), 1);
      check("lock_phase", int'(u_if.cur_phase), 0);
      check("lock_no_en", n_up + n_dn, 0);
      check("lock_err", int'(u_if.err), 0);

      // ---- directed table ----
      for (int i = 0; i < 12; i++) begin
         run_cmd(tbl[i].kind, tbl[i].tgt, tbl[i].exp_ph, tbl[i].exp_up,
                 tbl[i].exp_dn, $sformatf("vec%0d", i), 1'b0);
      end

      // ---- retarget mid-move: +10, then +2 once phase reaches 4 ----
      up0 = n_up;
      dn0 = n_dn;
      strobe(K_SET, 10);
      for (int i = 0; i < 200 && u_if.cur_phase != 4; i++) @(negedge dcm_clk);
      check("rt_reach4", int'(u_if.cur_phase), 4);
      strobe(K_SET, 2);
      wait_idle("rt", 2000);
      check("rt_phase", int'(u_if.cur_phase), 2);
      check("rt_up", n_up - up0, 5);
      check("rt_dn", n_dn - dn0, 3);
      check("rt_err", int'(u_if.err), 0);
      m_cur = 2;

      // ---- randomized commands ----
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       tgt = -256;
               1:       tgt = 255;
               2:       tgt = -255;
               default: tgt = 254;
            endcase
         end else begin
            tgt = m_cur + int'($urandom_range(0, 40)) - 20;
            if (tgt > 255)  tgt = 255;
            if (tgt < -256) tgt = -256;
         end
         lat = int'($urandom_range(3, 6));
         exp = model_next(kind, tgt, m_cur);
         run_cmd(kind, tgt, exp,
                 (exp > m_cur) ? exp - m_cur : 0,
                 (exp < m_cur) ? m_cur - exp : 0,
                 $sformatf("rnd%0d", n),
                 (exp != m_cur) && ($urandom_range(0, 1) == 1));
      end

      // ---- done timeout: bring phase to 2, then the DCM hangs ----
      lat = 4;
      run_cmd(K_SET, 2, 2, (m_cur < 2) ? 2 - m_cur : 0,
              (m_cur > 2) ? m_cur - 2 : 0, "tmo_prep", 1'b0);
      hang = 1'b1;
      strobe(K_INC, 0);
      wait_en("tmo", 5);
      repeat (60) @(negedge dcm_clk);
      check("tmo_not_early_err", int'(u_if.err), 0);
      check("tmo_not_early_busy", int'(u_if.busy), 1);
      wait_idle("tmo", 15);
      check("tmo_err", int'(u_if.err), 1);
      check("tmo_phase", int'(u_if.cur_phase), 2);
      hang   = 1'b0;
      dcm_ph = 2;
      repeat (3) @(negedge dcm_clk);
      check("tmo_err_held", int'(u_if.err), 1);
      run_cmd(K_INC, 0, 3, 1, 0, "tmo_clear", 1'b0);

      // ---- lock loss during WAIT_DONE at phase 5 ----
      run_cmd(K_SET, 5, 5, 2, 0, "ll_prep", 1'b0);
      lat = 20;
      strobe(K_SET, 8);
      wait_en("ll", 5);
      repeat (3) @(negedge dcm_clk);
      u_if.locked = 1'b0;
      up0 = n_up;
      dn0 = n_dn;
      repeat (4) @(negedge dcm_clk);
      check("ll_err", int'(u_if.err), 1);
      check("ll_busy", int'(u_if.busy), 1);
      repeat (20) @(negedge dcm_clk);
      check("ll_no_en", (n_up - up0) + (n_dn - dn0), 0);
      check("ll_busy_held", int'(u_if.busy), 1);
      u_if.locked = 1'b1;
      lat = 4;
      wait_idle("ll_relock", 10);
      check("ll_phase", int'(u_if.cur_phase), 5);
      check("ll_err_sticky", int'(u_if.err), 1);

      // ---- asynchronous reset during a step ----
      strobe(K_SET, 9);
      wait_en("rs", 5);
      check("rs_incdec_before", int'(u_if.dcm_incdec), 1);
      #1 dcm_rst = 1'b1;
      #1;
      check("rs_en", int'(u_if.dcm_en), 0);
      check("rs_incdec", int'(u_if.dcm_incdec), 0);
      check("rs_phase", int'(u_if.cur_phase), 0);
      check("rs_busy", int'(u_if.busy), 1);
      check("rs_err", int'(u_if.err), 0);
      repeat (2) @(negedge dcm_clk);
      dcm_rst = 1'b0;
      wait_idle("rs_relock", 10);
      check("rs_phase_idle", int'(u_if.cur_phase), 0);
      m_cur = 0;
      run_cmd(K_SET, 1, 1, 1, 0, "rs_after", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
